// File: rtl/perceptron_layer.sv
// perceptron_layer
//   M neurons share one N-element signed input vector and evaluate
//   y[m] = act(sat((b[m] + sum_k x[k]*w[m][k]) >>> SHIFT)).
//   Each neuron uses one MAC per cycle, so a result takes N MAC cycles.
//   One extra cycle quantises and activates the sums.
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : input handshake (x, w, b, act_mode latched on accept)
//   x [N], w [M][N]    : signed inputs and weights, DATA_WIDTH each
//   b [M]              : signed biases
//   act_mode           : 00 identity, 01 ReLU, 10 leaky ReLU, 11 ReLU
//   out_valid/out_ready: output handshake; y is held until accepted
//   y [M]              : signed activated outputs
module perceptron_layer #(
    parameter int N          = 4,
    parameter int M          = 2,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int SHIFT      = 0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [N-1:0][DATA_WIDTH-1:0]          x,
    input  logic [M-1:0][N-1:0][DATA_WIDTH-1:0]   w,
    input  logic [M-1:0][DATA_WIDTH-1:0]          b,
    input  logic [1:0]                            act_mode,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [M-1:0][DATA_WIDTH-1:0]          y
);

    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'((1 << (DATA_WIDTH-1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_LO = -SAT_HI - ACC_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, MAC, FINAL, OUT} state_t;

    state_t                               state, state_nx;
    logic [KW-1:0]                        k;
    logic [N-1:0][DATA_WIDTH-1:0]         x_r;
    logic [M-1:0][N-1:0][DATA_WIDTH-1:0]  w_r;
    logic [1:0]                           mode_r;
    logic signed [ACC_WIDTH-1:0]          acc     [M];
    logic signed [2*DATA_WIDTH-1:0]       prod    [M];
    logic signed [ACC_WIDTH-1:0]          shifted [M];
    logic signed [DATA_WIDTH-1:0]         sat     [M];
    logic [M-1:0][DATA_WIDTH-1:0]         y_nx;

    // Control: in_ready/out_valid decode the state only; in_ready is also
    // forced low while reset is asserted.
    always_comb begin
        state_nx  = state;
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == OUT);
        case (state)
            IDLE:    if (in_valid) state_nx = MAC;
            MAC:     if (k == KW'(N-1)) state_nx = FINAL;
            FINAL:   state_nx = OUT;
            OUT:     if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: one product per neuron for the current k, then
    // shift (floor), saturate and activate for the FINAL cycle.
    always_comb begin
        for (int unsigned m = 0; m < M; m++) begin
            prod[m]    = $signed(x_r[k]) * $signed(w_r[m][k]);
            shifted[m] = acc[m] >>> SHIFT;
            if (shifted[m] > SAT_HI)
                sat[m] = SAT_HI[DATA_WIDTH-1:0];
            else if (shifted[m] < SAT_LO)
                sat[m] = SAT_LO[DATA_WIDTH-1:0];
            else
                sat[m] = shifted[m][DATA_WIDTH-1:0];
            case (mode_r)
                2'b00:   y_nx[m] = sat[m];
                2'b10:   y_nx[m] = (sat[m] < 0) ? (sat[m] >>> 3) : sat[m];
                default: y_nx[m] = (sat[m] < 0) ? '0 : sat[m];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            k      <= '0;
            x_r    <= '0;
            w_r    <= '0;
            mode_r <= '0;
            y      <= '0;
            for (int unsigned m = 0; m < M; m++) acc[m] <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (in_valid) begin
                    x_r    <= x;
                    w_r    <= w;
                    mode_r <= act_mode;
                    k      <= '0;
                    for (int unsigned m = 0; m < M; m++)
                        acc[m] <= {{(ACC_WIDTH-DATA_WIDTH){b[m][DATA_WIDTH-1]}}, b[m]};
                end
                MAC: begin
                    for (int unsigned m = 0; m < M; m++)
                        acc[m] <= acc[m] + {{(ACC_WIDTH-2*DATA_WIDTH){prod[m][2*DATA_WIDTH-1]}}, prod[m]};
                    k <= (k == KW'(N-1)) ? '0 : k + KW'(1);
                end
                FINAL: y <= y_nx;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_layer.sv
module tb_perceptron_layer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst, in_valid, out_ready;
    logic [3:0][7:0]        x;
    logic [1:0][3:0][7:0]   w;
    logic [1:0][7:0]        b;
    logic [1:0]             act_mode;
    logic                   in_ready0, out_valid0, in_ready1, out_valid1;
    logic [1:0][7:0]        y0, y1;

    int total = 0;
    int bad   = 0;

    perceptron_layer #(.N(4), .M(2), .DATA_WIDTH(8), .ACC_WIDTH(32), .SHIFT(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .x(x), .w(w), .b(b), .act_mode(act_mode),
        .out_valid(out_valid0), .out_ready(out_ready), .y(y0));

    perceptron_layer #(.N(4), .M(2), .DATA_WIDTH(8), .ACC_WIDTH(32), .SHIFT(2)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .x(x), .w(w), .b(b), .act_mode(act_mode),
        .out_valid(out_valid1), .out_ready(out_ready), .y(y1));

    typedef struct {
        logic [3:0][7:0] xv;
        logic [3:0][7:0] w0;
        logic [3:0][7:0] w1;
        logic [7:0]      b0;
        logic [7:0]      b1;
        logic [1:0]      mode;
        int              e0, e1;   // expected y for SHIFT=0
        int              s0, s1;   // expected y for SHIFT=2
    } vec_t;

    vec_t vecs[8];

    function automatic logic [3:0][7:0] rep4(input int v);
        logic [7:0] e;
        e = 8'(v);
        return {e, e, e, e};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sy(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    task automatic apply(input vec_t v);
        x = v.xv; w[0] = v.w0; w[1] = v.w1;
        b[0] = v.b0; b[1] = v.b1; act_mode = v.mode;
    endtask

    task automatic scramble();
        x = $urandom; w = {$urandom, $urandom}; b = 16'($urandom); act_mode = 2'($urandom);
    endtask

    // Accept one vector, check latency and results, optionally hold
    // out_ready low for 6 cycles with ignored in_valid pulses, then handshake.
    task automatic run_vec(input vec_t v, input string nm, input bit hold);
        int cyc;
        bit seen;
        logic [1:0][7:0] ysave;
        @(negedge clk);
        apply(v);
        in_valid = 1'b1;
        chk({nm, "_in_ready"}, int'(in_ready0), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble();
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
            if (out_valid0) seen = 1'b1;
        end
        chk({nm, "_latency"}, cyc, 5);
        chk({nm, "_ovalid1"}, int'(out_valid1), 1);
        chk({nm, "_y0"}, sy(y0[0]), v.e0);
        chk({nm, "_y1"}, sy(y0[1]), v.e1);
        chk({nm, "_sh_y0"}, sy(y1[0]), v.s0);
        chk({nm, "_sh_y1"}, sy(y1[1]), v.s1);
        if (hold) begin
            ysave = y0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                in_valid = 1'b1;
                x = $urandom;
                @(posedge clk); #1;
                chk({nm, "_bp_ovalid"}, int'(out_valid0), 1);
                chk({nm, "_bp_iready"}, int'(in_ready0), 0);
                chk({nm, "_bp_y"}, int'(y0), int'(ysave));
            end
            in_valid = 1'b0;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, "_post_ovalid"}, int'(out_valid0), 0);
        chk({nm, "_post_iready"}, int'(in_ready0), 1);
    endtask

    initial begin
        int t[3];
        int nacc;
        int rises;

        vecs[0] = '{{8'd4, 8'd3, 8'd2, 8'd1}, rep4(1), rep4(-1), 8'd0, 8'd2, 2'b01, 10, 0, 2, 0};
        vecs[1] = '{{8'd4, 8'd3, 8'd2, 8'd1}, rep4(1), rep4(-1), 8'd0, 8'd2, 2'b00, 10, -8, 2, -2};
        vecs[2] = '{{8'd4, 8'd3, 8'd2, 8'd1}, rep4(1), rep4(-1), 8'd0, 8'd2, 2'b10, 10, -1, 2, -1};
        vecs[3] = '{{8'd4, 8'd3, 8'd2, 8'd1}, rep4(1), rep4(-1), 8'd0, 8'd2, 2'b11, 10, 0, 2, 0};
        vecs[4] = '{rep4(127), rep4(127), rep4(-128), 8'd0, 8'd0, 2'b00, 127, -128, 127, -128};
        vecs[5] = '{rep4(127), rep4(127), rep4(-128), 8'd0, 8'd0, 2'b01, 127, 0, 127, 0};
        vecs[6] = '{rep4(127), rep4(127), rep4(-128), 8'd0, 8'd0, 2'b10, 127, -16, 127, -16};
        vecs[7] = '{{8'd4, 8'd3, 8'd2, 8'd1}, rep4(1), rep4(-1), 8'd0, 8'd1, 2'b00, 10, -9, 2, -3};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        x = '0; w = '0; b = '0; act_mode = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready0), 0);
        chk("rst_out_valid", int'(out_valid0), 0);
        chk("rst_y", int'(y0), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", int'(in_ready0), 1);

        for (int i = 0; i < 8; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i), 1'b0);

        run_vec(vecs[1], "backpressure", 1'b1);

        // Reset two cycles after accept: no output must ever appear.
        @(negedge clk);
        apply(vecs[0]);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_in_ready", int'(in_ready0), 0);
        chk("midrst_out_valid", int'(out_valid0), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_after_in_ready", int'(in_ready0), 1);
        chk("midrst_after_y", int'(y0), 0);
        rises = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid0) rises++;
        end
        chk("midrst_no_output", rises, 0);

        // Throughput: in_valid and out_ready held high.
        @(negedge clk);
        apply(vecs[1]);
        in_valid = 1'b1;
        out_ready = 1'b1;
        nacc = 0;
        for (int c = 0; c < 60 && nacc < 3; c++) begin
            if (in_ready0) begin
                t[nacc] = c;
                nacc++;
            end
            if (nacc < 3) @(negedge clk);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("tput_accepts", nacc, 3);
        if (nacc == 3) begin
            chk("tput_gap1", t[1] - t[0], 7);
            chk("tput_gap2", t[2] - t[1], 7);
        end
        repeat (10) @(posedge clk);
        #1;
        chk("tput_drained", int'(in_ready0), 1);
        out_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
